pong_sprite_layer_engine: RTL
=============================

Name: pong_sprite_layer_engine

Overview:
Parametrised successor to the fixed two-paddle/one-ball pixel engine. It draws NUM_SPRITES independently positioned, sized, coloured rectangles on the pixel bus. Layering is by fixed priority, and each sprite has optional frame-rate blinking. It also reports per-frame sprite overlap (collision) flags back to the game logic. It sits between the game engine and the VGA pixel bus.

Parameters:
NUM_SPRITES, 4, number of sprite channels (1..16); index 0 has the highest priority
H_CNT_WID, 10, width of the horizontal counter and of sprite X/W fields
V_CNT_WID, 10, width of the vertical counter and of sprite Y/H fields
PIPELINE_STAGES, 2, cycles from pixIf_H_CNT to colour output (0 = combinational)
BLINK_WID, 5, frame counter width; blink phase = MSB
BG_COL, 12'h000, background colour {r,g,b}

Ports:
pixIf_CLK  in  1  pixel clock
pixIf_RST_N  in  1  asynchronous active-low reset
pixIf_NEXT_FRAME  in  1  one-cycle frame-start strobe
pixIf_H_BLANKING  in  1  high during horizontal blanking
pixIf_H_CNT  in  H_CNT_WID  current pixel X
pixIf_next_V_CNT  in  V_CNT_WID  Y of the line to be drawn next
spr_x  in  NUM_SPRITES*H_CNT_WID  left edge per sprite (sprite i at [i*W +: W])
spr_w  in  NUM_SPRITES*H_CNT_WID  width per sprite
spr_y  in  NUM_SPRITES*V_CNT_WID  top edge per sprite
spr_h  in  NUM_SPRITES*V_CNT_WID  height per sprite
spr_col  in  NUM_SPRITES*12  colour {r,g,b} per sprite
spr_en  in  NUM_SPRITES  sprite enable
spr_blink  in  NUM_SPRITES  sprite blinks when set
pixIf_r/pixIf_g/pixIf_b  out  4 each  pixel colour
hit_valid  out  1  some sprite is drawn at the current output pixel
hit_idx  out  $clog2(NUM_SPRITES) (min 1)  index of the winning sprite
frame_collision  out  NUM_SPRITES  bit i = sprite i overlapped another visible sprite in the previous frame

Behaviour:
- Reset (async assert, sync release):
  - Active sprite regs, yhit, delay line, collision accumulator, frame_collision and frame counter are all cleared.
  - Outputs: BG_COL, hit_valid=0, hit_idx=0.
- Shadow latch:
  - In a cycle with pixIf_NEXT_FRAME=1, all spr_* inputs are copied into the active regs, which take effect next cycle.
  - Inputs are otherwise ignored, so there is no mid-frame tearing.
- Frame counter:
  - Increments (wrapping) on pixIf_NEXT_FRAME.
  - vis[i] = act_en[i] & ~(act_blink[i] & cnt[BLINK_WID-1]).
- Y stage:
  - Every cycle with pixIf_H_BLANKING=1: yhit[i] <= vis[i] & (next_V_CNT >= y_i) & (next_V_CNT < y_i + h_i).
  - The sum is computed in V_CNT_WID+1 bits, so sprites at the bottom edge do not wrap.
  - yhit holds while H_BLANKING=0.
  - h_i=0 means the sprite is never drawn.
- X stage:
  - raw[i] = yhit[i] & (H_CNT >= x_i) & (H_CNT < x_i + w_i), with the sum in H_CNT_WID+1 bits.
  - raw feeds a PIPELINE_STAGES-deep shift register.
  - Colour, hit_valid and hit_idx for the H_CNT sampled at cycle t appear at cycle t+PIPELINE_STAGES.
  - With PIPELINE_STAGES=0 the path is purely combinational.
- Priority:
  - The lowest set index in the delayed raw vector wins, and its colour is output.
  - If no bit is set: BG_COL, hit_valid=0, hit_idx=0.
- Collision:
  - When popcount(delayed raw) >= 2, every set bit is OR-ed into the accumulator.
  - On pixIf_NEXT_FRAME: frame_collision <= accumulator | current-cycle contribution, then the accumulator clears.
  - frame_collision holds for the whole frame.
- Simultaneous events:
  - NEXT_FRAME together with H_BLANKING: the Y check in that cycle uses the pre-latch active regs. It is re-evaluated in the following blanking cycles, so the first visible line uses the new values.
- Reset mid-line: the next pixel after release is BG.

Test Plan:
- Reset, then one frame with all spr_en=0 -> every pixel 12'h000; hit_valid=0; frame_collision=0.
- Sprite 0: x=10, w=4, y=5, h=2, col=12'hF00; PIPELINE_STAGES=2 -> red exactly at X=10..13 on lines 5..6, appearing 2 cycles after H_CNT=10; X=14 and line 7 are BG.
- Sprite 0 and sprite 1 overlap at X=20..23 (sprite 1 col=12'h0F0) -> red shown in the overlap (hit_idx=0); after the next NEXT_FRAME, frame_collision=4'b0011.
- Change spr_x mid-frame without NEXT_FRAME -> the drawn position is unchanged until the next frame, then moves.
- spr_blink=1 with BLINK_WID=2 -> sprite visible for 2 frames, hidden for 2 frames, repeating.
- Edge case: y=HEIGHT-1 (1023), h=4 -> drawn only on line 1023, no wrap to line 0. Also assert pixIf_RST_N mid-line -> outputs go to BG asynchronously.

Source files
------------

// File: rtl/pong_sprite_layer_engine.sv
// Sprite layer engine: draws NUM_SPRITES prioritised, optionally blinking rectangles
// on the pixel bus and reports per-frame sprite overlaps back to the game logic.
module pong_sprite_layer_engine #(
  parameter int unsigned NUM_SPRITES     = 4,
  parameter int unsigned H_CNT_WID       = 10,
  parameter int unsigned V_CNT_WID       = 10,
  parameter int unsigned PIPELINE_STAGES = 2,
  parameter int unsigned BLINK_WID       = 5,
  parameter logic [11:0] BG_COL          = 12'h000,
  localparam int unsigned IdxWid = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                             pixIf_CLK,
  input  logic                             pixIf_RST_N,
  input  logic                             pixIf_NEXT_FRAME,
  input  logic                             pixIf_H_BLANKING,
  input  logic [H_CNT_WID-1:0]             pixIf_H_CNT,
  input  logic [V_CNT_WID-1:0]             pixIf_next_V_CNT,
  input  logic [NUM_SPRITES*H_CNT_WID-1:0] spr_x,
  input  logic [NUM_SPRITES*H_CNT_WID-1:0] spr_w,
  input  logic [NUM_SPRITES*V_CNT_WID-1:0] spr_y,
  input  logic [NUM_SPRITES*V_CNT_WID-1:0] spr_h,
  input  logic [NUM_SPRITES*12-1:0]        spr_col,
  input  logic [NUM_SPRITES-1:0]           spr_en,
  input  logic [NUM_SPRITES-1:0]           spr_blink,
  output logic [3:0]                       pixIf_r,
  output logic [3:0]                       pixIf_g,
  output logic [3:0]                       pixIf_b,
  output logic                             hit_valid,
  output logic [IdxWid-1:0]                hit_idx,
  output logic [NUM_SPRITES-1:0]           frame_collision
);

  logic [NUM_SPRITES*H_CNT_WID-1:0] act_x_q, act_w_q;
  logic [NUM_SPRITES*V_CNT_WID-1:0] act_y_q, act_h_q;
  logic [NUM_SPRITES*12-1:0]        act_col_q;
  logic [NUM_SPRITES-1:0]           act_en_q, act_blink_q;
  logic [BLINK_WID-1:0]             cnt_q;

  logic [NUM_SPRITES-1:0] vis;
  logic [NUM_SPRITES-1:0] yhit_d, yhit_q;
  logic [NUM_SPRITES-1:0] raw;
  logic [NUM_SPRITES-1:0] del;
  logic                   multi;
  logic [NUM_SPRITES-1:0] contrib;
  logic [NUM_SPRITES-1:0] acc_q;
  logic [NUM_SPRITES-1:0] frame_coll_q;
  logic [11:0]            col_sel;
  logic                   hit_sel;
  logic [IdxWid-1:0]      idx_sel;

  // Shadow latch: sprite parameters only change at frame start, so a frame never tears.
  always_ff @(posedge pixIf_CLK or negedge pixIf_RST_N) begin
    if (!pixIf_RST_N) begin
      act_x_q     <= '0;
      act_w_q     <= '0;
      act_y_q     <= '0;
      act_h_q     <= '0;
      act_col_q   <= '0;
      act_en_q    <= '0;
      act_blink_q <= '0;
    end else if (pixIf_NEXT_FRAME) begin
      act_x_q     <= spr_x;
      act_w_q     <= spr_w;
      act_y_q     <= spr_y;
      act_h_q     <= spr_h;
      act_col_q   <= spr_col;
      act_en_q    <= spr_en;
      act_blink_q <= spr_blink;
    end
  end

  // Frame counter; its MSB is the blink phase.
  always_ff @(posedge pixIf_CLK or negedge pixIf_RST_N) begin
    if (!pixIf_RST_N) begin
      cnt_q <= '0;
    end else if (pixIf_NEXT_FRAME) begin
      cnt_q <= cnt_q + BLINK_WID'(1);
    end
  end

  assign vis = act_en_q & ~(act_blink_q & {NUM_SPRITES{cnt_q[BLINK_WID-1]}});

  // Vertical test for the upcoming line, refreshed on every blanking cycle.
  always_comb begin : y_check
    logic [V_CNT_WID:0] v_ext;
    logic [V_CNT_WID:0] y_top;
    logic [V_CNT_WID:0] y_end;
    v_ext  = {1'b0, pixIf_next_V_CNT};
    y_top  = '0;
    y_end  = '0;
    yhit_d = yhit_q;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      y_top = {1'b0, act_y_q[i*V_CNT_WID +: V_CNT_WID]};
      // Extra bit keeps bottom-edge sprites from wrapping to the top lines.
      y_end = y_top + {1'b0, act_h_q[i*V_CNT_WID +: V_CNT_WID]};
      if (pixIf_H_BLANKING) begin
        yhit_d[i] = vis[i] & (v_ext >= y_top) & (v_ext < y_end);
      end
    end
  end

  // Per-line vertical hit register, held across the active part of the line.
  always_ff @(posedge pixIf_CLK or negedge pixIf_RST_N) begin
    if (!pixIf_RST_N) begin
      yhit_q <= '0;
    end else begin
      yhit_q <= yhit_d;
    end
  end

  // Horizontal test against the current pixel.
  always_comb begin : x_check
    logic [H_CNT_WID:0] h_ext;
    logic [H_CNT_WID:0] x_lft;
    logic [H_CNT_WID:0] x_end;
    h_ext = {1'b0, pixIf_H_CNT};
    x_lft = '0;
    x_end = '0;
    raw   = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      x_lft  = {1'b0, act_x_q[i*H_CNT_WID +: H_CNT_WID]};
      x_end  = x_lft + {1'b0, act_w_q[i*H_CNT_WID +: H_CNT_WID]};
      raw[i] = yhit_q[i] & (h_ext >= x_lft) & (h_ext < x_end);
    end
  end

  if (PIPELINE_STAGES == 0) begin : g_comb
    assign del = raw;
  end else begin : g_pipe
    logic [NUM_SPRITES-1:0] pipe_q [PIPELINE_STAGES];

    // Delay line aligning the hit vector with the downstream pixel timing.
    always_ff @(posedge pixIf_CLK or negedge pixIf_RST_N) begin
      if (!pixIf_RST_N) begin
        for (int s = 0; s < PIPELINE_STAGES; s++) begin
          pipe_q[s] <= '0;
        end
      end else begin
        pipe_q[0] <= raw;
        for (int s = 1; s < PIPELINE_STAGES; s++) begin
          pipe_q[s] <= pipe_q[s-1];
        end
      end
    end

    assign del = pipe_q[PIPELINE_STAGES-1];
  end

  // Fixed priority: the lowest set index wins, so scan downwards and let it overwrite.
  always_comb begin
    hit_sel = 1'b0;
    idx_sel = '0;
    col_sel = BG_COL;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (del[i]) begin
        hit_sel = 1'b1;
        idx_sel = IdxWid'(i);
        col_sel = act_col_q[i*12 +: 12];
      end
    end
  end

  // Two or more sprites on the same pixel all count as colliding.
  always_comb begin : overlap
    logic seen_one;
    seen_one = 1'b0;
    multi    = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (del[i]) begin
        if (seen_one) begin
          multi = 1'b1;
        end
        seen_one = 1'b1;
      end
    end
    contrib = multi ? del : '0;
  end

  // Collision accumulator, published and cleared at every frame start.
  always_ff @(posedge pixIf_CLK or negedge pixIf_RST_N) begin
    if (!pixIf_RST_N) begin
      acc_q        <= '0;
      frame_coll_q <= '0;
    end else if (pixIf_NEXT_FRAME) begin
      acc_q        <= '0;
      frame_coll_q <= acc_q | contrib;
    end else begin
      acc_q        <= acc_q | contrib;
    end
  end

  assign pixIf_r         = col_sel[11:8];
  assign pixIf_g         = col_sel[7:4];
  assign pixIf_b         = col_sel[3:0];
  assign hit_valid       = hit_sel;
  assign hit_idx         = idx_sel;
  assign frame_collision = frame_coll_q;

endmodule
